// File: rtl/binop_sched_if.sv
// Request/response bundle between two requesters, the shared operator scheduler
// and the response consumer.
interface binop_sched_if #(
  parameter int WIDTH = 8
);
  logic             req0_valid;
  logic             req0_ready;
  logic [3:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [3:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface

// File: rtl/binop_sched.sv
// Round-robin scheduler sharing one binary-operator datapath between two requesters;
// single-cycle ops answer next cycle, DIV/MOD iterate one quotient bit per cycle.
module binop_sched #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  binop_sched_if.slave  bus,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, DIV, RESP} state_t;

  localparam int              CNT_W   = $clog2(WIDTH + 1);
  localparam logic [3:0]      OP_DIV  = 4'd12;
  localparam logic [3:0]      OP_MOD  = 4'd13;
  localparam logic [WIDTH:0]  WIDTH_L = (WIDTH + 1)'(WIDTH);

  state_t             state, state_nxt;
  logic               rr_last;
  logic               grant, accept, div_start;
  logic [3:0]         sel_op;
  logic [WIDTH-1:0]   sel_a, sel_b;
  logic [CNT_W-1:0]   cnt;
  logic               rsp_id_q, rsp_err_q;
  logic [WIDTH-1:0]   rsp_data_q;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   dvs, quo, rem, quo_nxt, rem_nxt, div_res;
  logic [WIDTH:0]     shifted, diff;

  // Returns {err, data} for every opcode that completes in one cycle.
  function automatic logic [WIDTH:0] alu(input logic [3:0] op,
                                         input logic [WIDTH-1:0] a,
                                         input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] sa;
    logic                    big;
    logic [WIDTH-1:0]        r;
    logic                    err;
    sa  = signed'(a);
    big = ({1'b0, b} >= WIDTH_L);
    r   = '0;
    err = 1'b0;
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  r = a ^ b;
      4'd3:  r = ~(a ^ b);
      4'd4:  r = big ? '0 : (a << b);
      4'd5:  r = big ? '0 : (a >> b);
      4'd6:  r = big ? {WIDTH{a[WIDTH-1]}} : $unsigned(sa >>> b);
      4'd7:  r = {{(WIDTH-1){1'b0}}, (a < b)};
      4'd8:  r = {{(WIDTH-1){1'b0}}, (a == b)};
      4'd9:  r = a + b;
      4'd10: r = a - b;
      4'd11: r = a * b;
      4'd12: begin r = '1; err = 1'b1; end
      4'd13: begin r = a;  err = 1'b1; end
      default: begin r = '0; err = 1'b1; end
    endcase
    return {err, r};
  endfunction

  // Grant in IDLE: a lone valid wins, a tie goes to the one not granted last.
  always_comb begin
    grant  = 1'b0;
    accept = 1'b0;
    if (state == IDLE) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant  = ~rr_last;
        accept = 1'b1;
      end else if (bus.req0_valid) begin
        accept = 1'b1;
      end else if (bus.req1_valid) begin
        grant  = 1'b1;
        accept = 1'b1;
      end
    end
  end

  assign sel_op    = grant ? bus.req1_op : bus.req0_op;
  assign sel_a     = grant ? bus.req1_a  : bus.req0_a;
  assign sel_b     = grant ? bus.req1_b  : bus.req0_b;
  assign div_start = accept && ((sel_op == OP_DIV) || (sel_op == OP_MOD)) && (sel_b != '0);

  // Restoring division step: shift in the next dividend bit, subtract if it fits.
  assign shifted = {rem, quo[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs};
  assign rem_nxt = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_nxt = {quo[WIDTH-2:0], ~diff[WIDTH]};
  assign div_res = (op_q == OP_DIV) ? quo_nxt : rem_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = div_start ? DIV : RESP;
      DIV:     if (cnt == CNT_W'(1)) state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last    <= 1'b1;
      rsp_id_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      cnt        <= '0;
    end else if (accept) begin
      rr_last  <= grant;
      rsp_id_q <= grant;
      cnt      <= CNT_W'(WIDTH);
      if (!div_start) {rsp_err_q, rsp_data_q} <= alu(sel_op, sel_a, sel_b);
    end else if (state == DIV) begin
      cnt <= cnt - 1'b1;
      if (cnt == CNT_W'(1)) begin
        rsp_data_q <= div_res;
        rsp_err_q  <= 1'b0;
      end
    end
  end

  // Division working registers carry data only; the FSM decides when they matter.
  always_ff @(posedge clk) begin
    if (div_start) begin
      op_q <= sel_op;
      dvs  <= sel_b;
      quo  <= sel_a;
      rem  <= '0;
    end else if (state == DIV) begin
      quo <= quo_nxt;
      rem <= rem_nxt;
    end
  end

  assign bus.req0_ready = accept && !grant;
  assign bus.req1_ready = accept && grant;
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_err    = rsp_err_q;
  assign busy           = (state != IDLE);
endmodule

// File: tb/tb_binop_sched.sv
// Directed bench for binop_sched: vector table of single ops plus arbitration,
// back-pressure and mid-operation reset sequences.
module tb_binop_sched;
  localparam int W = 8;

  typedef struct {
    logic       id;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] data;
    logic       err;
    int         lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   errors = 0;
  int   checks = 0;
  vec_t vecs[26];

  binop_sched_if #(.WIDTH(W)) bus();

  binop_sched #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_req(input logic id, input logic v, input logic [3:0] op,
                           input logic [7:0] a, input logic [7:0] b);
    if (!id) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},      32'(busy), 0);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
    check({tag, "_rsp_data"},  32'(bus.rsp_data), 0);
    check({tag, "_rsp_err"},   32'(bus.rsp_err), 0);
    check({tag, "_rsp_id"},    32'(bus.rsp_id), 0);
  endtask

  // Issue one op, optionally keep the other requester asking while it is in flight.
  task automatic do_op(input vec_t v, input bit hold_other);
    int   cyc;
    logic rdy, ordy;
    @(negedge clk);
    drive_req(v.id, 1'b1, v.op, v.a, v.b);
    #1;
    rdy = v.id ? bus.req1_ready : bus.req0_ready;
    check("accept_ready", 32'(rdy), 1);
    @(posedge clk);
    #1;
    drive_req(v.id, 1'b0, ~v.op, ~v.a, 8'h00);
    if (hold_other) drive_req(~v.id, 1'b1, 4'd0, 8'hFF, 8'hFF);
    cyc = 1;
    @(negedge clk);
    while (!bus.rsp_valid && cyc < 40) begin
      ordy = v.id ? bus.req0_ready : bus.req1_ready;
      if (hold_other) check("other_ready_in_div", 32'(ordy), 0);
      @(negedge clk);
      cyc++;
    end
    check("latency",  32'(cyc), 32'(v.lat));
    check("rsp_data", 32'(bus.rsp_data), 32'(v.data));
    check("rsp_err",  32'(bus.rsp_err), 32'(v.err));
    check("rsp_id",   32'(bus.rsp_id), 32'(v.id));
    bus.rsp_ready = 1'b1;
    if (hold_other) drive_req(~v.id, 1'b0, 4'd0, 8'h00, 8'h00);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("rsp_valid_after_hs", 32'(bus.rsp_valid), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int   n, guard, seen;
    logic g[4];

    drive_req(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
    drive_req(1'b1, 1'b0, 4'd0, 8'h00, 8'h00);
    bus.rsp_ready = 1'b0;

    vecs[0]  = '{1'b0, 4'd9,  8'd200, 8'd100, 8'd44,  1'b0, 1};
    vecs[1]  = '{1'b0, 4'd0,  8'hF0,  8'h3C,  8'h30,  1'b0, 1};
    vecs[2]  = '{1'b1, 4'd1,  8'hF0,  8'h0C,  8'hFC,  1'b0, 1};
    vecs[3]  = '{1'b0, 4'd2,  8'hA5,  8'h0F,  8'hAA,  1'b0, 1};
    vecs[4]  = '{1'b1, 4'd3,  8'hA5,  8'hFF,  8'hA5,  1'b0, 1};
    vecs[5]  = '{1'b0, 4'd4,  8'h01,  8'd8,   8'h00,  1'b0, 1};
    vecs[6]  = '{1'b0, 4'd4,  8'h03,  8'd2,   8'h0C,  1'b0, 1};
    vecs[7]  = '{1'b1, 4'd5,  8'h80,  8'd7,   8'h01,  1'b0, 1};
    vecs[8]  = '{1'b0, 4'd5,  8'h90,  8'd200, 8'h00,  1'b0, 1};
    vecs[9]  = '{1'b0, 4'd6,  8'h90,  8'd9,   8'hFF,  1'b0, 1};
    vecs[10] = '{1'b1, 4'd6,  8'h90,  8'd2,   8'hE4,  1'b0, 1};
    vecs[11] = '{1'b0, 4'd6,  8'h70,  8'd3,   8'h0E,  1'b0, 1};
    vecs[12] = '{1'b0, 4'd7,  8'd3,   8'd5,   8'd1,   1'b0, 1};
    vecs[13] = '{1'b1, 4'd7,  8'd5,   8'd3,   8'd0,   1'b0, 1};
    vecs[14] = '{1'b0, 4'd8,  8'd7,   8'd7,   8'd1,   1'b0, 1};
    vecs[15] = '{1'b0, 4'd10, 8'd3,   8'd5,   8'hFE,  1'b0, 1};
    vecs[16] = '{1'b1, 4'd11, 8'd20,  8'd13,  8'd4,   1'b0, 1};
    vecs[17] = '{1'b1, 4'd12, 8'd200, 8'd7,   8'd28,  1'b0, 9};
    vecs[18] = '{1'b1, 4'd13, 8'd200, 8'd7,   8'd4,   1'b0, 9};
    vecs[19] = '{1'b0, 4'd12, 8'd5,   8'd0,   8'hFF,  1'b1, 1};
    vecs[20] = '{1'b1, 4'd13, 8'd9,   8'd0,   8'd9,   1'b1, 1};
    vecs[21] = '{1'b0, 4'd14, 8'd1,   8'd2,   8'd0,   1'b1, 1};
    vecs[22] = '{1'b1, 4'd15, 8'd1,   8'd2,   8'd0,   1'b1, 1};
    vecs[23] = '{1'b0, 4'd12, 8'd255, 8'd1,   8'd255, 1'b0, 9};
    vecs[24] = '{1'b0, 4'd13, 8'd255, 8'd16,  8'd15,  1'b0, 9};
    vecs[25] = '{1'b0, 4'd8,  8'd7,   8'd6,   8'd0,   1'b0, 1};

    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_req0_ready", 32'(bus.req0_ready), 0);
    check("reset_req1_ready", 32'(bus.req1_ready), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 26; i++) do_op(vecs[i], vecs[i].lat > 1);

    // Fresh reset so the tie pointer starts from its reset value.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle_outputs("rr_reset");
    rst_n = 1'b1;
    drive_req(1'b0, 1'b1, 4'd0, 8'hF0, 8'h3C);
    drive_req(1'b1, 1'b1, 4'd0, 8'h0F, 8'hFF);
    bus.rsp_ready = 1'b1;
    n = 0;
    guard = 0;
    while (n < 4 && guard < 40) begin
      #1;
      if (bus.req0_ready) begin g[n] = 1'b0; n++; end
      else if (bus.req1_ready) begin g[n] = 1'b1; n++; end
      if (bus.rsp_valid)
        check("rr_rsp_data", 32'(bus.rsp_data), bus.rsp_id ? 32'h0F : 32'h30);
      @(negedge clk);
      guard++;
    end
    check("rr_grant_count", 32'(n), 4);
    for (int i = 0; i < n; i++) check("rr_grant_order", 32'(g[i]), 32'(i % 2));
    drive_req(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
    drive_req(1'b1, 1'b0, 4'd0, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("rr_idle_after", 32'(busy), 0);

    // Back-pressure: response must hold steady while the consumer stalls.
    @(negedge clk);
    drive_req(1'b1, 1'b1, 4'd2, 8'hA5, 8'hFF);
    @(posedge clk);
    #1;
    drive_req(1'b1, 1'b0, 4'd9, 8'h00, 8'h00);
    guard = 0;
    @(negedge clk);
    while (!bus.rsp_valid && guard < 20) begin @(negedge clk); guard++; end
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(bus.rsp_valid), 1);
      check("stall_data",  32'(bus.rsp_data), 32'h5A);
      check("stall_id",    32'(bus.rsp_id), 1);
      check("stall_err",   32'(bus.rsp_err), 0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("stall_released", 32'(bus.rsp_valid), 0);

    // Reset in the middle of a division: nothing may come out afterwards.
    @(negedge clk);
    drive_req(1'b1, 1'b1, 4'd12, 8'd200, 8'd7);
    @(posedge clk);
    #1;
    drive_req(1'b1, 1'b0, 4'd0, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    check("div_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_rsp_valid", 32'(bus.rsp_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    check("rst_no_rsp", 32'(seen), 0);
    do_op(vecs[0], 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
